// File: rtl/button_pio_ctrl.sv
// Avalon-MM master that services a 3-bit button PIO: programs irq_mask, reads edge_capture
// and pin levels on interrupt, clears the capture, waits out a debounce holdoff, queues events.
module button_pio_ctrl #(
    parameter logic [2:0]  MASK_INIT      = 3'b111,
    parameter logic [15:0] HOLDOFF_CYCLES = 16'd50000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] pio_address,
    output logic       pio_chipselect,
    output logic       pio_write_n,
    output logic [2:0] pio_writedata,
    input  logic [2:0] pio_readdata,
    input  logic       pio_irq,
    input  logic       mask_valid,
    input  logic [2:0] mask_data,
    output logic       mask_ack,
    output logic       evt_valid,
    output logic [5:0] evt_data,
    input  logic       evt_ready,
    output logic       overflow,
    input  logic       overflow_clr,
    output logic       busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [2:0] StInit  = 3'd0;
    localparam logic [2:0] StIdle  = 3'd1;
    localparam logic [2:0] StRdEc  = 3'd2;
    localparam logic [2:0] StRdLvl = 3'd3;
    localparam logic [2:0] StClr   = 3'd4;
    localparam logic [2:0] StHold  = 3'd5;
    localparam logic [2:0] StPush  = 3'd6;

    localparam logic [1:0] AddrData = 2'd0;
    localparam logic [1:0] AddrMask = 2'd2;
    localparam logic [1:0] AddrEdge = 2'd3;

    logic [2:0]      state_q, state_d;
    logic [2:0]      ec_q, ec_d;
    logic [2:0]      lvl_q, lvl_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            overflow_q, overflow_d;
    logic [5:0]      mem_q [FIFO_DEPTH];

    logic fifo_full, push_try, push, pop, drop;

    // Bus outputs are decoded from the current state (and, in IDLE, from the request inputs)
    // so each access lands in the same cycle the state is entered.
    always_comb begin
        state_d        = state_q;
        ec_d           = ec_q;
        lvl_d          = lvl_q;
        cnt_d          = cnt_q;
        pio_address    = 2'd0;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_writedata  = 3'd0;
        mask_ack       = 1'b0;
        case (state_q)
            StInit: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = AddrMask;
                pio_writedata  = MASK_INIT;
                state_d        = StIdle;
            end
            StIdle: begin
                if (mask_valid) begin
                    pio_chipselect = 1'b1;
                    pio_write_n    = 1'b0;
                    pio_address    = AddrMask;
                    pio_writedata  = mask_data;
                    mask_ack       = 1'b1;
                end else if (pio_irq) begin
                    pio_address = AddrEdge;
                    state_d     = StRdEc;
                end
            end
            StRdEc: begin
                ec_d        = pio_readdata;
                pio_address = AddrData;
                state_d     = StRdLvl;
            end
            StRdLvl: begin
                lvl_d       = pio_readdata;
                pio_address = AddrEdge;
                state_d     = StClr;
            end
            StClr: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = AddrEdge;
                pio_writedata  = 3'b111;
                cnt_d          = HOLDOFF_CYCLES;
                state_d        = StHold;
            end
            StHold: begin
                cnt_d = cnt_q - 16'd1;
                // Leave once the decremented count reaches 1.
                if (cnt_q <= 16'd2) begin
                    state_d = StPush;
                end
            end
            StPush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StInit;
            end
        endcase
        if (reset) begin
            pio_address    = 2'd0;
            pio_chipselect = 1'b0;
            pio_write_n    = 1'b1;
            pio_writedata  = 3'd0;
            mask_ack       = 1'b0;
        end
    end

    assign busy      = (state_q != StIdle);
    assign evt_valid = (count_q != '0);
    assign fifo_full = (count_q == CntW'(FIFO_DEPTH));
    assign pop       = evt_valid & evt_ready;
    // A zero edge_capture means the interrupt went away (e.g. mask changed); nothing to report.
    assign push_try  = (state_q == StPush) && (ec_q != 3'd0);
    assign push      = push_try && (!fifo_full || pop);
    assign drop      = push_try && fifo_full && !pop;
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 6'd0;
    assign overflow  = overflow_q;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StInit;
            ec_q       <= 3'd0;
            lvl_q      <= 3'd0;
            cnt_q      <= 16'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ec_q       <= ec_d;
            lvl_q      <= lvl_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {lvl_q, ec_q};
        end
    end

endmodule
